// File: rtl/crypto1_key_collector.sv
// Harvests 48-bit keys from an array of Crypto1 search cores, lowest index first, and hands each
// key to the host over a valid/ready handshake; flags exhaustion once every core is done.
module crypto1_key_collector #(
  parameter int unsigned NUM_CORES = 16,
  parameter int unsigned KEY_BITS  = 48,
  parameter int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_CORES-1:0] CORE_DONE,
  input  logic [NUM_CORES-1:0] CORE_KEY_VALID,
  input  logic [NUM_CORES-1:0] CORE_KEY_DATA,
  output logic [NUM_CORES-1:0] CORE_KEY_CLK,
  output logic [KEY_BITS-1:0]  KEY,
  output logic [IDX_W-1:0]     KEY_IDX,
  output logic                 KEY_OUT_VALID,
  input  logic                 KEY_OUT_READY,
  output logic                 SEARCH_DONE,
  output logic                 NONE_FOUND
);

  localparam int unsigned CntW = $clog2(KEY_BITS + 1);

  typedef enum logic [1:0] {StScan, StShift, StPresent, StIdleDone} state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] harvested_q, harvested_d;
  logic [NUM_CORES-1:0] pending;
  logic                 found_any_q, found_any_d;
  logic [IDX_W-1:0]     sel_q, sel_d, lowest_idx;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [KEY_BITS-1:0]  key_q, key_d;
  logic                 search_done_q, search_done_d;
  logic                 none_found_q, none_found_d;

  assign pending = CORE_KEY_VALID & CORE_DONE & ~harvested_q;

  // Descending scan so the lowest set index wins.
  always_comb begin
    lowest_idx = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (pending[i]) lowest_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    harvested_d   = harvested_q;
    found_any_d   = found_any_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    key_d         = key_q;
    search_done_d = search_done_q;
    none_found_d  = none_found_q;
    CORE_KEY_CLK  = '0;

    unique case (state_q)
      StScan: begin
        if (|pending) begin
          sel_d   = lowest_idx;
          cnt_d   = '0;
          state_d = StShift;
        end else if (&CORE_DONE) begin
          search_done_d = 1'b1;
          none_found_d  = ~found_any_q;
          state_d       = StIdleDone;
        end
      end
      StShift: begin
        if (cnt_q < CntW'(KEY_BITS)) CORE_KEY_CLK[sel_q] = 1'b1;
        // Core data is registered, so sampling lags the shift enable by one cycle.
        if (cnt_q != '0) key_d = {key_q[KEY_BITS-2:0], CORE_KEY_DATA[sel_q]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(KEY_BITS)) state_d = StPresent;
      end
      StPresent: begin
        if (KEY_OUT_READY) begin
          harvested_d[sel_q] = 1'b1;
          found_any_d        = 1'b1;
          state_d            = StScan;
        end
      end
      StIdleDone: begin
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StScan;
      harvested_q   <= '0;
      found_any_q   <= 1'b0;
      sel_q         <= '0;
      cnt_q         <= '0;
      key_q         <= '0;
      search_done_q <= 1'b0;
      none_found_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      harvested_q   <= harvested_d;
      found_any_q   <= found_any_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      key_q         <= key_d;
      search_done_q <= search_done_d;
      none_found_q  <= none_found_d;
    end
  end

  assign KEY           = key_q;
  assign KEY_IDX       = sel_q;
  assign KEY_OUT_VALID = (state_q == StPresent);
  assign SEARCH_DONE   = search_done_q;
  assign NONE_FOUND    = none_found_q;

endmodule

// File: tb/tb_crypto1_key_collector.sv
// Randomized and directed bench for crypto1_key_collector against a cycle-timeline reference
// model and a set of serial-key core models.
module tb_crypto1_key_collector;

  localparam int unsigned NC = 8;
  localparam int unsigned KB = 48;
  localparam int unsigned IW = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NC-1:0] CORE_DONE, CORE_KEY_VALID, CORE_KEY_DATA, CORE_KEY_CLK;
  logic [KB-1:0] KEY;
  logic [IW-1:0] KEY_IDX;
  logic          KEY_OUT_VALID, KEY_OUT_READY, SEARCH_DONE, NONE_FOUND;

  crypto1_key_collector #(.NUM_CORES(NC), .KEY_BITS(KB), .IDX_W(IW)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CORE_DONE      (CORE_DONE),
    .CORE_KEY_VALID (CORE_KEY_VALID),
    .CORE_KEY_DATA  (CORE_KEY_DATA),
    .CORE_KEY_CLK   (CORE_KEY_CLK),
    .KEY            (KEY),
    .KEY_IDX        (KEY_IDX),
    .KEY_OUT_VALID  (KEY_OUT_VALID),
    .KEY_OUT_READY  (KEY_OUT_READY),
    .SEARCH_DONE    (SEARCH_DONE),
    .NONE_FOUND     (NONE_FOUND)
  );

  always #5 CLK = ~CLK;

  // Core models: each shifts its key out MSB first when enabled and finished.
  logic [KB-1:0] core_key [NC];
  logic [NC-1:0] core_rst;
  int            sh [NC];

  always @(posedge CLK) begin
    for (int i = 0; i < int'(NC); i++) begin
      if (core_rst[i]) begin
        sh[i]            <= 0;
        CORE_KEY_DATA[i] <= 1'b0;
      end else if (CORE_KEY_CLK[i] && CORE_DONE[i]) begin
        CORE_KEY_DATA[i] <= (sh[i] < int'(KB)) ? core_key[i][int'(KB) - 1 - sh[i]] : 1'b0;
        sh[i]            <= sh[i] + 1;
      end
    end
  end

  // Reference model: phase 0 scan, 1 serving (timeline from decision), 2 presenting, 3 done.
  int            cyc = 0;
  bit            m_init = 1'b0;
  int            m_phase, m_start, m_sel;
  logic [KB-1:0] m_key;
  logic [NC-1:0] m_harv, m_pend, m_low;
  bit            m_found, m_sdone, m_nf;

  int            acc_idx [$];
  logic [KB-1:0] acc_key [$];
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    cyc++;
    if (RESET) begin
      m_init  = 1'b1;
      m_phase = 0;
      m_harv  = '0;
      m_found = 1'b0;
      m_sdone = 1'b0;
      m_nf    = 1'b0;
    end else if (m_init) begin
      case (m_phase)
        0: begin
          m_pend = CORE_KEY_VALID & CORE_DONE & ~m_harv;
          if (m_pend != '0) begin
            m_low   = m_pend & (~m_pend + NC'(1));
            m_sel   = $clog2(m_low);
            m_key   = core_key[m_sel];
            m_start = cyc;
            m_phase = 1;
          end else if (&CORE_DONE) begin
            m_sdone = 1'b1;
            m_nf    = !m_found;
            m_phase = 3;
          end
        end
        1: if (cyc == m_start + int'(KB) + 1) m_phase = 2;
        2: if (KEY_OUT_READY) begin
          m_harv[m_sel] = 1'b1;
          m_found       = 1'b1;
          m_phase       = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    logic [NC-1:0] exp_clk;
    if (!m_init) return;
    exp_clk = '0;
    if (m_phase == 1 && (cyc - m_start) < int'(KB)) exp_clk = NC'(1) << m_sel;
    chk("key_clk", CORE_KEY_CLK, exp_clk);
    chk("key_out_valid", KEY_OUT_VALID, m_phase == 2);
    if (m_phase == 2) begin
      chk("key", KEY, m_key);
      chk("key_idx", KEY_IDX, m_sel);
    end
    chk("search_done", SEARCH_DONE, m_sdone);
    chk("none_found", NONE_FOUND, m_nf);
  endtask

  task automatic tick();
    if (!RESET && KEY_OUT_VALID === 1'b1 && KEY_OUT_READY) begin
      acc_idx.push_back(int'(KEY_IDX));
      acc_key.push_back(KEY);
    end
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare();
  endtask

  task automatic do_reset();
    RESET          = 1'b1;
    CORE_DONE      = '0;
    CORE_KEY_VALID = '0;
    KEY_OUT_READY  = 1'b0;
    core_rst       = '1;
    for (int i = 0; i < int'(NC); i++) core_key[i] = '0;
    tick();
    tick();
    RESET    = 1'b0;
    core_rst = '0;
    acc_idx.delete();
    acc_key.delete();
  endtask

  task automatic load(input int i, input logic [KB-1:0] k, input bit v);
    core_key[i]       = k;
    CORE_DONE[i]      = 1'b1;
    CORE_KEY_VALID[i] = v;
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    while (KEY_OUT_VALID !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(name, KEY_OUT_VALID, 1'b1);
  endtask

  task automatic wait_sdone(input string name, input int bound);
    int n = 0;
    while (SEARCH_DONE !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(name, SEARCH_DONE, 1'b1);
  endtask

  task automatic wait_acc(input int cnt, input int bound);
    int n = 0;
    while (acc_idx.size() < cnt && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [KB-1:0] k, k0;
    logic [NC-1:0] vmask;
    int n, nclk, nv;

    RESET          = 1'b1;
    CORE_DONE      = '0;
    CORE_KEY_VALID = '0;
    KEY_OUT_READY  = 1'b0;
    core_rst       = '1;

    // Reset state
    do_reset();
    chk("rst_key_clk", CORE_KEY_CLK, 8'h00);
    chk("rst_key", KEY, 48'h0);
    chk("rst_key_idx", KEY_IDX, 3'd0);
    chk("rst_valid", KEY_OUT_VALID, 1'b0);
    chk("rst_sdone", SEARCH_DONE, 1'b0);
    chk("rst_none", NONE_FOUND, 1'b0);

    // Single key on core 2, others done without a key
    KEY_OUT_READY = 1'b1;
    for (int i = 0; i < int'(NC); i++) load(i, 48'h0, 1'b0);
    load(2, 48'hA5A5_1234_5678, 1'b1);
    n    = 0;
    nclk = 0;
    while (KEY_OUT_VALID !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (CORE_KEY_CLK == 8'b0000_0100) nclk++;
    end
    chk("single_latency", n, 50);
    chk("single_clk_cycles", nclk, 48);
    chk("single_key", KEY, 48'hA5A5_1234_5678);
    chk("single_idx", KEY_IDX, 3'd2);
    tick();
    wait_sdone("single_sdone", 10);
    chk("single_none", NONE_FOUND, 1'b0);

    // Exhaustion: done one cycle after the last DONE
    do_reset();
    CORE_DONE = '1;
    tick();
    chk("exh_sdone", SEARCH_DONE, 1'b1);
    chk("exh_none", NONE_FOUND, 1'b1);
    repeat (5) tick();
    chk("exh_key_clk", CORE_KEY_CLK, 8'h00);

    // Simultaneous finds on cores 3 and 1
    do_reset();
    KEY_OUT_READY = 1'b1;
    load(3, 48'h1, 1'b1);
    load(1, 48'hFFFF_FFFF_FFFF, 1'b1);
    wait_acc(2, 300);
    for (int i = 0; i < int'(NC); i++) CORE_DONE[i] = 1'b1;
    wait_sdone("simul_sdone", 20);
    chk("simul_count", acc_idx.size(), 2);
    if (acc_idx.size() >= 2) begin
      chk("simul_idx0", acc_idx[0], 1);
      chk("simul_key0", acc_key[0], 48'hFFFF_FFFF_FFFF);
      chk("simul_idx1", acc_idx[1], 3);
      chk("simul_key1", acc_key[1], 48'h0000_0000_0001);
    end
    chk("simul_none", NONE_FOUND, 1'b0);

    // Backpressure
    do_reset();
    k = KB'({$urandom(), $urandom()});
    load(4, k, 1'b1);
    wait_valid("bp_wait_valid", 100);
    repeat (100) tick();
    chk("bp_valid_held", KEY_OUT_VALID, 1'b1);
    chk("bp_key_held", KEY, k);
    KEY_OUT_READY = 1'b1;
    tick();
    chk("bp_accept", KEY_OUT_VALID, 1'b0);
    chk("bp_acc_count", acc_idx.size(), 1);

    // Reset at shift cycle 20, then full re-harvest of the same core
    do_reset();
    KEY_OUT_READY = 1'b1;
    k = KB'({$urandom(), $urandom()});
    load(6, k, 1'b1);
    n = 0;
    while (CORE_KEY_CLK == '0 && n < 5) begin
      tick();
      n++;
    end
    repeat (19) tick();
    chk("mid_shift_active", CORE_KEY_CLK, 8'b0100_0000);
    RESET       = 1'b1;
    core_rst[6] = 1'b1;
    tick();
    chk("mid_rst_key_clk", CORE_KEY_CLK, 8'h00);
    chk("mid_rst_key", KEY, 48'h0);
    chk("mid_rst_idx", KEY_IDX, 3'd0);
    chk("mid_rst_valid", KEY_OUT_VALID, 1'b0);
    RESET    = 1'b0;
    core_rst = '0;
    wait_valid("mid_rewait", 100);
    chk("mid_rekey", KEY, k);
    chk("mid_reidx", KEY_IDX, 3'd6);

    // Late lower index: core 0 arrives while core 5 is shifting
    do_reset();
    KEY_OUT_READY = 1'b1;
    k  = KB'({$urandom(), $urandom()});
    k0 = KB'({$urandom(), $urandom()});
    load(5, k, 1'b1);
    repeat (10) tick();
    chk("late_shift5", CORE_KEY_CLK, 8'b0010_0000);
    load(0, k0, 1'b1);
    wait_acc(2, 300);
    chk("late_count", acc_idx.size(), 2);
    if (acc_idx.size() >= 2) begin
      chk("late_idx0", acc_idx[0], 5);
      chk("late_key0", acc_key[0], k);
      chk("late_idx1", acc_idx[1], 0);
      chk("late_key1", acc_key[1], k0);
    end

    // Randomized rounds: valid raised early, DONE trickles in, random READY
    for (int r = 0; r < 6; r++) begin
      do_reset();
      vmask = NC'($urandom());
      if (r == 0) vmask = '0;
      for (int i = 0; i < int'(NC); i++) core_key[i] = KB'({$urandom(), $urandom()});
      CORE_KEY_VALID = vmask;
      nv = $countones(vmask);
      n  = 0;
      while (SEARCH_DONE !== 1'b1 && n < 3000) begin
        for (int i = 0; i < int'(NC); i++) begin
          if ($urandom_range(0, 15) == 0) CORE_DONE[i] = 1'b1;
        end
        KEY_OUT_READY = $urandom_range(0, 1) == 1;
        tick();
        n++;
      end
      chk("rand_sdone", SEARCH_DONE, 1'b1);
      chk("rand_count", acc_idx.size(), nv);
      chk("rand_none", NONE_FOUND, vmask == '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
